// File: rtl/vexriscv_ram_pkg.sv
// Shared types and helpers for the VexRiscv data-RAM port controller.
package vexriscv_ram_pkg;

  localparam int RAM_WIDTH_DEF = 32;
  localparam int RAM_DEPTH_DEF = 8192;

  typedef enum logic [1:0] {IDLE, RD_RSP, RMW_WR} state_e;
  typedef enum logic {CPU = 1'b0, LDR = 1'b1} req_e;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Lanes with mask set take the new byte, others keep the word read from RAM.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++)
      if (mask[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/vexriscv_rr_arb2.sv
// Two-requester round-robin arbiter; last_q doubles as the owner of the op in flight.
module vexriscv_rr_arb2
  import vexriscv_ram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output req_e       last
);

  req_e last_q, last_d;

  always_comb begin
    grant  = req;
    if (req == 2'b11) grant = (last_q == LDR) ? 2'b01 : 2'b10;
    last_d = last_q;
    if (accept && grant[0])      last_d = CPU;
    else if (accept && grant[1]) last_d = LDR;
  end

  always_ff @(posedge clk) begin
    if (reset) last_q <= LDR;
    else       last_q <= last_d;
  end

  assign last = last_q;

endmodule

// File: rtl/vexriscv_dbus_ram_ctrl.sv
// Data-port controller for the VexRiscv RAM: CPU/loader arbitration, load responses and
// read-modify-write for byte-masked stores. Loader port enabled by `define VEXRAM_LOADER_EN.
module vexriscv_dbus_ram_ctrl
  import vexriscv_ram_pkg::*;
#(
  parameter  int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter  int RAM_DEPTH = RAM_DEPTH_DEF,
  localparam int ADDR_W    = addr_w(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_cmd_valid,
  output logic                 cpu_cmd_ready,
  input  logic                 cpu_cmd_wr,
  input  logic [31:0]          cpu_cmd_addr,
  input  logic [RAM_WIDTH-1:0] cpu_cmd_data,
  input  logic [3:0]           cpu_cmd_mask,
  output logic                 cpu_rsp_valid,
  output logic [RAM_WIDTH-1:0] cpu_rsp_data,
  input  logic                 ldr_cmd_valid,
  output logic                 ldr_cmd_ready,
  input  logic                 ldr_cmd_wr,
  input  logic [ADDR_W-1:0]    ldr_cmd_addr,
  input  logic [RAM_WIDTH-1:0] ldr_cmd_data,
  output logic                 ldr_rsp_valid,
  output logic [RAM_WIDTH-1:0] ldr_rsp_data,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  input  logic [RAM_WIDTH-1:0] ram_dout
);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [RAM_WIDTH-1:0]   data_q, data_d;
  logic [3:0]             mask_q, mask_d;
  logic [RAM_WIDTH-1:0]   cpu_rsp_data_q, cpu_rsp_data_d;
  logic [RAM_WIDTH-1:0]   ldr_rsp_data_q, ldr_rsp_data_d;

  logic                   ldr_req, idle;
  logic [1:0]             grant;
  req_e                   owner;
  logic                   c_wr;
  logic [ADDR_W-1:0]      c_addr;
  logic [RAM_WIDTH-1:0]   c_data;
  logic [3:0]             c_mask;

`ifdef VEXRAM_LOADER_EN
  assign ldr_req = ldr_cmd_valid;
`else
  logic unused_ldr;
  assign unused_ldr = ldr_cmd_valid;
  assign ldr_req    = 1'b0;
`endif

  // Byte offset and bits above the RAM size are dropped: addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{cpu_cmd_addr[31:ADDR_W+2], cpu_cmd_addr[1:0]};

  assign idle = (state_q == IDLE) && !reset;

  vexriscv_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({ldr_req, cpu_cmd_valid}),
    .accept (idle),
    .grant  (grant),
    .last   (owner)
  );

  always_comb begin
    if (grant[1]) begin
      c_wr   = ldr_cmd_wr;
      c_addr = ldr_cmd_addr;
      c_data = ldr_cmd_data;
      c_mask = 4'hF;
    end else begin
      c_wr   = cpu_cmd_wr;
      c_addr = cpu_cmd_addr[ADDR_W+1:2];
      c_data = cpu_cmd_data;
      c_mask = cpu_cmd_mask;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    mask_d         = mask_q;
    cpu_rsp_data_d = cpu_rsp_data_q;
    ldr_rsp_data_d = ldr_rsp_data_q;
    cpu_cmd_ready  = 1'b0;
    ldr_cmd_ready  = 1'b0;
    cpu_rsp_valid  = 1'b0;
    ldr_rsp_valid  = 1'b0;
    ram_en         = 1'b0;
    ram_we         = 1'b0;
    ram_addr       = addr_q;
    ram_din        = data_q;
    case (state_q)
      IDLE: begin
        if (idle && (grant != 2'b00)) begin
          cpu_cmd_ready = grant[0];
          ldr_cmd_ready = grant[1];
          addr_d        = c_addr;
          data_d        = c_data;
          mask_d        = c_mask;
          ram_addr      = c_addr;
          ram_din       = c_data;
          if (!c_wr) begin
            ram_en  = 1'b1;
            state_d = RD_RSP;
          end else if (c_mask == 4'hF) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end else if (c_mask != 4'h0) begin
            ram_en  = 1'b1;
            state_d = RMW_WR;
          end
        end
      end
      RD_RSP: begin
        if (owner == CPU) begin
          cpu_rsp_valid  = 1'b1;
          cpu_rsp_data_d = ram_dout;
        end else begin
          ldr_rsp_valid  = 1'b1;
          ldr_rsp_data_d = ram_dout;
        end
        state_d = IDLE;
      end
      RMW_WR: begin
        ram_en  = 1'b1;
        ram_we  = 1'b1;
        ram_din = byte_merge(ram_dout, data_q, mask_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset kills the in-flight op, including a pending RMW write.
    if (reset) begin
      cpu_cmd_ready  = 1'b0;
      ldr_cmd_ready  = 1'b0;
      cpu_rsp_valid  = 1'b0;
      ldr_rsp_valid  = 1'b0;
      ram_en         = 1'b0;
      ram_we         = 1'b0;
      cpu_rsp_data_d = '0;
      ldr_rsp_data_d = '0;
      state_d        = IDLE;
    end
  end

  assign cpu_rsp_data = cpu_rsp_data_d;
  assign ldr_rsp_data = ldr_rsp_data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      data_q         <= '0;
      mask_q         <= '0;
      cpu_rsp_data_q <= '0;
      ldr_rsp_data_q <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      mask_q         <= mask_d;
      cpu_rsp_data_q <= cpu_rsp_data_d;
      ldr_rsp_data_q <= ldr_rsp_data_d;
    end
  end

endmodule
